apb_write_checker: RTL and testbench
====================================

APB_WRITE_CHECKER -- requirements
Module: apb_write_checker

Interface
REQ-001 The block SHALL have parameter NREGS, default DSP_REGISTERS, giving the number of checked 32-bit registers (1..64).
REQ-002 The block SHALL have parameter BASE_ADDR, default CFG_REG_ADDRESS, giving the address of register 0; register i lives at BASE_ADDR+4*i.
REQ-003 The block SHALL have parameter LATENCY, default 1, range 1..4: cycles after write completion at which the register output must hold PWDATA.
REQ-004 The block SHALL have these ports, clock and reset first:
 clk  in  1  single clock, posedge
 rst_n  in  1  reset, asynchronous, active-low
 PSEL, PENABLE, PWRITE, PREADY  in  1 each  observed APB control
 PADDR, PWDATA  in  32 each  observed APB address/write data
 regs_in  in  NREGS x 32  observed register outputs of the DUT
 clr_in  in  1  clears sticky flags and counter
 err_proto  out  1  sticky APB protocol violation
 err_addr  out  1  sticky write to unmapped/unaligned address
 err_data  out  1  sticky register value mismatch
 err_count  out  16  total errors, saturating
 last_err_addr  out  32  PADDR of most recent error
 chk_busy  out  1  at least one data check pending

Function
REQ-005 The block SHALL track the bus with FSM states IDLE, SETUP, ACCESS, evaluated at posedge clk.
REQ-006 IDLE->SETUP on PSEL&&!PENABLE; SETUP->ACCESS on PSEL&&PENABLE; ACCESS with PREADY -> SETUP if PSEL&&!PENABLE, else IDLE; ACCESS without PREADY stays ACCESS.
REQ-007 A protocol error SHALL be flagged for: PENABLE high in IDLE; SETUP not followed by PSEL&&PENABLE; PSEL dropping during ACCESS before PREADY; PADDR, PWRITE or PWDATA changing between SETUP and completing ACCESS cycle.
REQ-008 After a protocol error the FSM SHALL return to IDLE, or to SETUP if PSEL&&!PENABLE in that cycle.
REQ-009 A write completes in the ACCESS cycle with PSEL&&PENABLE&&PWRITE&&PREADY; read transfers SHALL be checked for protocol only.
REQ-010 A completed write with PADDR[1:0]!=0, PADDR<BASE_ADDR, or index>=NREGS SHALL flag err_addr and schedule no data check.
REQ-011 A valid completed write SHALL push {index, PWDATA} into a LATENCY-deep pending pipeline advancing every cycle.
REQ-012 Exactly LATENCY cycles after completion, regs_in[index] SHALL be compared with the stored data; inequality flags err_data.
REQ-013 Back-to-back writes (one per two cycles) SHALL each be checked independently; no check is ever dropped.
REQ-014 Each error flag SHALL assert one cycle after the offending posedge and stay high until clr_in or reset.
REQ-015 err_count SHALL increment by the number of distinct error kinds detected in a cycle (0..3) and saturate at 16'hFFFF.
REQ-016 last_err_addr SHALL capture PADDR of the offending transfer (stored address for err_data); priority data > addr > proto when simultaneous.
REQ-017 clr_in SHALL clear flags and err_count next cycle; an error detected in the same cycle as clr_in SHALL win (flag set, count = its increment).
REQ-018 chk_busy SHALL be the OR of pending-pipeline valid bits.
REQ-019 The block SHALL be observation-only: no APB outputs and no combinational path from inputs to outputs.

Reset
REQ-020 On rst_n low, asynchronously: FSM=IDLE, pipeline valids=0, all flags=0, err_count=0, last_err_addr=0, chk_busy=0.
REQ-021 Reset mid-transfer SHALL discard pending checks; the first cycle after release is IDLE with no error for the aborted transfer.

Structure
REQ-022 The FSM state enum and an error-kind enum SHALL be placed in audioport_util_pkg; BASE_ADDR default and DSP_REGISTERS come from audioport_pkg.
REQ-023 The pending pipeline SHALL be a sub-module apb_check_pipe (parameters LATENCY, NREGS).

Verification
REQ-024 Write 32'hA5A5_0001 to BASE_ADDR, regs_in[0] updated 1 cycle after completion, LATENCY=1 -> no flags, err_count=0.
REQ-025 Same write, regs_in[0] updated 2 cycles after completion -> err_data=1, err_count=1, last_err_addr=BASE_ADDR.
REQ-026 LATENCY=3, writes to indices 1 and 2 back-to-back with 2 PREADY-low wait states each -> both checked, chk_busy high, no errors.
REQ-027 Write to BASE_ADDR+4*NREGS and to BASE_ADDR+2 -> err_addr=1, err_count=2, no err_data.
REQ-028 PWDATA changed during a wait state; PENABLE high in IDLE -> err_proto=1, err_count=2; clr_in with concurrent error -> err_count=1.
REQ-029 rst_n low during ACCESS with pending check -> all outputs 0 immediately, no error after release.

Source files
------------

// File: rtl/audioport_pkg.sv
// Audioport-wide constants shared by the register-level blocks.
package audioport_pkg;

  // Number of 32-bit DSP configuration registers.
  localparam int DSP_REGISTERS = 8;

  // Bus address of the first configuration register.
  localparam logic [31:0] CFG_REG_ADDRESS = 32'h8C00_0000;

endpackage

// File: rtl/audioport_util_pkg.sv
// Shared types and helpers for the APB bus checker.
package audioport_util_pkg;

  // Phase of the most recently sampled bus cycle that belongs to an open transfer.
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // Error kinds in rising priority order (data beats addr beats proto).
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PROTO = 2'd1,
    ERR_ADDR  = 2'd2,
    ERR_DATA  = 2'd3
  } err_kind_t;

  // Width of a register index; at least one bit so a single register still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // 16-bit counter add that sticks at all ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/apb_check_pipe.sv
// Delay line of pending data checks. Each completed write enters as
// {index, data} and emerges exactly LATENCY cycles later for comparison.
// push is a one-cycle strobe with no backpressure: the line advances every
// cycle, so a new entry can be accepted on every clock and none is dropped.
module apb_check_pipe
  import audioport_util_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int NREGS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [idx_width(NREGS)-1:0]   push_idx,
  input  logic [31:0]                   push_data,
  output logic                          chk_valid,
  output logic [idx_width(NREGS)-1:0]   chk_idx,
  output logic [31:0]                   chk_data,
  output logic                          busy
);

  localparam int IW = idx_width(NREGS);

  logic [LATENCY-1:0] valid_q;
  logic [IW-1:0]      idx_q  [LATENCY];
  logic [31:0]        data_q [LATENCY];

  // Shift register of pending checks; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= push;
      idx_q[0]   <= push_idx;
      data_q[0]  <= push_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign chk_valid = valid_q[LATENCY-1];
  assign chk_idx   = idx_q[LATENCY-1];
  assign chk_data  = data_q[LATENCY-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/apb_write_checker.sv
// Passive APB write checker. Watches the bus for protocol violations,
// flags writes outside the register window, and confirms that each mapped
// register shows the written value a fixed number of cycles after the write.
// All outputs come straight from flops.
module apb_write_checker
  import audioport_pkg::*;
  import audioport_util_pkg::*;
#(
  parameter int          NREGS     = DSP_REGISTERS,
  parameter logic [31:0] BASE_ADDR = CFG_REG_ADDRESS,
  parameter int          LATENCY   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic                   PREADY,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  input  logic [NREGS-1:0][31:0] regs_in,
  input  logic                   clr_in,
  output logic                   err_proto,
  output logic                   err_addr,
  output logic                   err_data,
  output logic [15:0]            err_count,
  output logic [31:0]            last_err_addr,
  output logic                   chk_busy
);

  localparam int IW = idx_width(NREGS);

  // state names the phase of the last sampled cycle of an open transfer;
  // SETUP and ACCESS both mean the current sample must be an access cycle.
  apb_state_t  state, next_state;
  logic        cap_en, complete, proto_det, stable_err;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write;

  logic [31:0] offset;
  logic        addr_bad, write_done, addr_det, push;
  logic [IW-1:0] push_idx;

  logic          chk_valid;
  logic [IW-1:0] chk_idx;
  logic [31:0]   chk_data, chk_reg;
  logic          data_det;

  err_kind_t   top_kind;
  logic [31:0] err_addr_sel;
  logic [1:0]  inc;

  // Address, direction and write data must hold from setup until completion.
  // Write data is only meaningful on writes, so reads ignore it.
  assign stable_err = (PADDR != cap_addr) || (PWRITE != cap_write) ||
                      (cap_write && (PWDATA != cap_wdata));

  // Bus phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= APB_IDLE;
    else        state <= next_state;
  end

  // Bus phase tracking and protocol violation detection.
  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    complete   = 1'b0;
    proto_det  = 1'b0;
    unique case (state)
      APB_IDLE: begin
        if (PENABLE) begin
          proto_det = 1'b1;
        end else if (PSEL) begin
          next_state = APB_SETUP;
          cap_en     = 1'b1;
        end
      end
      APB_SETUP, APB_ACCESS: begin
        if (PSEL && PENABLE) begin
          if (stable_err) begin
            proto_det  = 1'b1;
            next_state = APB_IDLE;
          end else if (PREADY) begin
            complete   = 1'b1;
            next_state = APB_IDLE;
          end else begin
            next_state = APB_ACCESS;
          end
        end else begin
          // Missing access phase, or select/enable dropped during wait states.
          proto_det = 1'b1;
          if (PSEL) begin
            next_state = APB_SETUP;
            cap_en     = 1'b1;
          end else begin
            next_state = APB_IDLE;
          end
        end
      end
      default: next_state = APB_IDLE;
    endcase
  end

  // Snapshot of the setup-phase signals for the stability check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
    end else if (cap_en) begin
      cap_addr  <= PADDR;
      cap_wdata <= PWDATA;
      cap_write <= PWRITE;
    end
  end

  // Decode of a completed write against the register window.
  assign offset     = PADDR - BASE_ADDR;
  assign addr_bad   = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) ||
                      (offset[31:2] >= 30'(NREGS));
  assign write_done = complete && PWRITE;
  assign addr_det   = write_done && addr_bad;
  assign push       = write_done && !addr_bad;
  assign push_idx   = offset[IW+1:2];

  apb_check_pipe #(
    .LATENCY (LATENCY),
    .NREGS   (NREGS)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_idx  (push_idx),
    .push_data (PWDATA),
    .chk_valid (chk_valid),
    .chk_idx   (chk_idx),
    .chk_data  (chk_data),
    .busy      (chk_busy)
  );

  // Select the register named by the emerging check entry.
  always_comb begin
    chk_reg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i == int'(chk_idx)) chk_reg = regs_in[i];
    end
  end

  assign data_det = chk_valid && (chk_reg != chk_data);
  assign inc      = {1'b0, proto_det} + {1'b0, addr_det} + {1'b0, data_det};

  // Pick the highest-priority error of this cycle and the address to report.
  always_comb begin
    top_kind     = ERR_NONE;
    err_addr_sel = PADDR;
    if (data_det) begin
      top_kind     = ERR_DATA;
      err_addr_sel = BASE_ADDR + (32'(chk_idx) << 2);
    end else if (addr_det) begin
      top_kind = ERR_ADDR;
    end else if (proto_det) begin
      top_kind = ERR_PROTO;
    end
  end

  // Sticky flags, saturating count and last error address; a fresh error wins over clr_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_proto     <= 1'b0;
      err_addr      <= 1'b0;
      err_data      <= 1'b0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      err_proto <= (err_proto && !clr_in) || proto_det;
      err_addr  <= (err_addr  && !clr_in) || addr_det;
      err_data  <= (err_data  && !clr_in) || data_det;
      err_count <= sat_add16(clr_in ? 16'd0 : err_count, inc);
      if (top_kind != ERR_NONE) last_err_addr <= err_addr_sel;
    end
  end

endmodule

// File: tb/tb_apb_write_checker.sv
// Directed bench for apb_write_checker: two checkers (LATENCY 1 and 3) watch
// the same bus, each with its own model of the observed register file.
module tb_apb_write_checker;
  import audioport_pkg::*;

  localparam logic [31:0] B = CFG_REG_ADDRESS;

  logic clk, rst_n;
  logic psel, penable, pwrite, pready, clr;
  logic [31:0] paddr, pwdata;
  logic [7:0][31:0] regs1, regs3;

  logic p1, a1, d1, busy1, p3, a3, d3, busy3;
  logic [15:0] cnt1, cnt3;
  logic [31:0] last1, last3;

  int total, bad;

  // entry = {dut_sel, busy, proto, addr, data, count[15:0], last_addr[31:0]}
  logic [52:0] exp_q[$];
  string       name_q[$];
  logic [52:0] mon_e, mon_a;
  string       mon_n;

  apb_write_checker #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PREADY(pready), .PADDR(paddr), .PWDATA(pwdata), .regs_in(regs1), .clr_in(clr),
    .err_proto(p1), .err_addr(a1), .err_data(d1), .err_count(cnt1),
    .last_err_addr(last1), .chk_busy(busy1)
  );

  apb_write_checker #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PREADY(pready), .PADDR(paddr), .PWDATA(pwdata), .regs_in(regs3), .clr_in(clr),
    .err_proto(p3), .err_addr(a3), .err_data(d3), .err_count(cnt3),
    .last_err_addr(last3), .chk_busy(busy3)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: one expected entry per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      if (mon_e[52]) mon_a = {1'b1, busy3, p3, a3, d3, cnt3, last3};
      else           mon_a = {1'b0, busy1, p1, a1, d1, cnt1, last1};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s: got busy=%0b p=%0b a=%0b d=%0b cnt=%0d last=%h, want busy=%0b p=%0b a=%0b d=%0b cnt=%0d last=%h",
                 mon_n, mon_a[51], mon_a[50], mon_a[49], mon_a[48], mon_a[47:32], mon_a[31:0],
                 mon_e[51], mon_e[50], mon_e[49], mon_e[48], mon_e[47:32], mon_e[31:0]);
      end
    end
  end

  task automatic expect_out(input logic sel, input logic bz, input logic p, input logic a,
                            input logic d, input logic [15:0] c, input logic [31:0] last,
                            input string nm);
    exp_q.push_back({sel, bz, p, a, d, c, last});
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0; pready = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // register model update, dly cycles after the completion edge
  task automatic sched_upd(input int which, input int dly, input int ix, input logic [31:0] v);
    fork
      begin
        repeat (dly - 1) begin @(posedge clk); #1; end
        if (which == 0) regs1[ix] = v;
        else            regs3[ix] = v;
      end
    join_none
  endtask

  // one APB transfer; returns 1 time unit after the completion edge
  task automatic apb_xfer(input logic [31:0] a, input logic [31:0] d, input logic wr,
                          input int waits, input int dl1, input int dl3);
    int ix;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pready = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; pready = (waits == 0);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      pready = (i == waits - 1);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pready = 1'b0;
    ix = int'((a - B) >> 2);
    if (wr && dl1 > 0) sched_upd(0, dl1, ix, d);
    if (wr && dl3 > 0) sched_upd(1, dl3, ix, d);
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; clr = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pready = 1'b0;
    paddr = '0; pwdata = '0; regs1 = '0; regs3 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    expect_out(0, 0, 0, 0, 0, 16'd0, 32'h0, "reset_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "reset_l3");
    idle(2);

    // register follows one cycle after the write
    apb_xfer(B, 32'hA5A5_0001, 1'b1, 0, 1, 1);
    idle(4);
    expect_out(0, 0, 0, 0, 0, 16'd0, 32'h0, "wr_ok_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "wr_ok_l3");
    idle(2);

    // register follows two cycles after: late for LATENCY 1, fine for 3
    regs1[0] = 32'h0; regs3[0] = 32'h0;
    apb_xfer(B, 32'hA5A5_0001, 1'b1, 0, 2, 2);
    idle(5);
    expect_out(0, 0, 0, 0, 1, 16'd1, B, "wr_late_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "wr_late_l3");
    idle(2);
    clear_flags();
    idle(1);
    expect_out(0, 0, 0, 0, 0, 16'd0, B, "clr_l1");
    idle(2);

    // back-to-back writes with two wait states each
    apb_xfer(B + 32'd4, 32'h1111_0001, 1'b1, 2, 1, 1);
    apb_xfer(B + 32'd8, 32'h2222_0002, 1'b1, 2, 1, 1);
    expect_out(0, 1, 0, 0, 0, 16'd0, B, "b2b_busy_l1");
    expect_out(1, 1, 0, 0, 0, 16'd0, 32'h0, "b2b_busy_l3");
    idle(6);
    expect_out(0, 0, 0, 0, 0, 16'd0, B, "b2b_done_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "b2b_done_l3");
    idle(2);

    // address window: last valid index, one past the end, unaligned, below base
    apb_xfer(B + 32'd28, 32'h7777_0007, 1'b1, 0, 1, 1);
    apb_xfer(B + 32'd32, 32'hDEAD_0020, 1'b1, 0, 0, 0);
    apb_xfer(B + 32'd2, 32'hDEAD_0002, 1'b1, 1, 0, 0);
    idle(5);
    expect_out(0, 0, 0, 1, 0, 16'd2, B + 32'd2, "addr_l1");
    expect_out(1, 0, 0, 1, 0, 16'd2, B + 32'd2, "addr_l3");
    idle(2);
    apb_xfer(B - 32'd4, 32'hDEAD_FFFC, 1'b1, 0, 0, 0);
    idle(2);
    expect_out(0, 0, 0, 1, 0, 16'd3, B - 32'd4, "addr_below_l1");
    idle(1);
    clear_flags();
    idle(1);
    expect_out(1, 0, 0, 0, 0, 16'd0, B - 32'd4, "clr_addr_l3");
    idle(2);

    // write data changes during a wait state
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 32'd12; pwdata = 32'h3333_0003;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    pwdata = 32'h3333_0004;
    @(posedge clk); #1;
    idle(2);
    expect_out(0, 0, 1, 0, 0, 16'd1, B + 32'd12, "proto_wdata_l1");
    expect_out(1, 0, 1, 0, 0, 16'd1, B + 32'd12, "proto_wdata_l3");
    idle(2);

    // PENABLE high while idle
    paddr = 32'h0000_1234; penable = 1'b1;
    @(posedge clk); #1;
    idle(2);
    expect_out(0, 0, 1, 0, 0, 16'd2, 32'h0000_1234, "proto_idle_l1");
    idle(1);

    // clear in the same cycle as a new error: the error wins
    paddr = 32'h0000_5678; penable = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    idle(2);
    expect_out(0, 0, 1, 0, 0, 16'd1, 32'h0000_5678, "clr_vs_err_l1");
    expect_out(1, 0, 1, 0, 0, 16'd1, 32'h0000_5678, "clr_vs_err_l3");
    idle(2);
    clear_flags();

    // a read to an unaligned address is checked for protocol only
    apb_xfer(B + 32'd2, 32'h0, 1'b0, 0, 0, 0);
    idle(2);
    expect_out(0, 0, 0, 0, 0, 16'd0, 32'h0000_5678, "read_unaligned_l1");
    idle(2);

    // reset during an access phase with a check still pending
    apb_xfer(B + 32'd4, 32'hDEAD_0001, 1'b1, 0, 0, 0);
    expect_out(1, 1, 0, 0, 0, 16'd0, 32'h0000_5678, "pend_busy_l3");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 32'd8; pwdata = 32'h2222_0002;
    @(posedge clk); #1;
    expect_out(0, 0, 0, 0, 1, 16'd1, B + 32'd4, "pend_mismatch_l1");
    penable = 1'b1; pready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    expect_out(0, 0, 0, 0, 0, 16'd0, 32'h0, "in_reset_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "in_reset_l3");
    psel = 1'b0; penable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle(5);
    expect_out(0, 0, 0, 0, 0, 16'd0, 32'h0, "after_reset_l1");
    expect_out(1, 0, 0, 0, 0, 16'd0, 32'h0, "after_reset_l3");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
